// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: Zicsr read-modify-write sequencer plus trap-entry and fetch-redirect initiator
module csr_access_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_rs1_data,
  input  logic [4:0]  req_rs1_idx,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        csr_wen,
  input  logic [31:0] csr_rdata,
  input  logic        csr_valid,
  input  logic        exc_valid,
  input  logic [5:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        irq_pending,
  input  logic [31:0] irq_pc,
  input  logic        mie,
  output logic [5:0]  trap_cause,
  output logic [31:0] trap_pc,
  output logic        trap_en,
  input  logic [31:0] trap_handler,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_RESP, S_TRAP, S_REDIR} state_t;
  state_t      r_state;
  logic [1:0]  r_kind;
  logic [31:0] r_operand;
  logic        r_nz;
  logic [31:0] r_old;
  logic [3:0]  r_cnt;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_illegal;
  logic [11:0] r_csr_addr;
  logic [31:0] r_csr_wdata;
  logic        r_csr_wen;
  logic [5:0]  r_trap_cause;
  logic [31:0] r_trap_pc;
  logic        r_trap_en;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic        w_trap;
  logic        w_write;
  logic        w_ro;
  logic [31:0] w_new;
  assign w_trap  = exc_valid || (irq_pending && mie);
  assign w_write = (r_kind == 2'b01) || r_nz;
  assign w_ro    = r_csr_addr[11:10] == 2'b11;
  assign w_new   = (r_kind == 2'b01) ? r_operand :
                   (r_kind == 2'b10) ? (csr_rdata | r_operand) : (csr_rdata & ~r_operand);
  assign req_ready      = !RST && (r_state == S_IDLE) && !w_trap;
  assign resp_valid     = r_resp_valid;
  assign resp_rdata     = r_resp_rdata;
  assign resp_illegal   = r_resp_illegal;
  assign csr_addr       = r_csr_addr;
  assign csr_wdata      = r_csr_wdata;
  assign csr_wen        = r_csr_wen;
  assign trap_cause     = r_trap_cause;
  assign trap_pc        = r_trap_pc;
  assign trap_en        = r_trap_en;
  assign redirect_valid = r_redirect_valid;
  // the handler is live during the redirect cycle and remembered afterwards
  assign redirect_pc    = r_redirect_valid ? trap_handler : r_redirect_pc;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state          <= S_IDLE;
      r_kind           <= '0;
      r_operand        <= '0;
      r_nz             <= 1'b0;
      r_old            <= '0;
      r_cnt            <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_rdata     <= '0;
      r_resp_illegal   <= 1'b0;
      r_csr_addr       <= '0;
      r_csr_wdata      <= '0;
      r_csr_wen        <= 1'b0;
      r_trap_cause     <= '0;
      r_trap_pc        <= '0;
      r_trap_en        <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_resp_valid     <= 1'b0;
      r_resp_illegal   <= 1'b0;
      r_csr_wen        <= 1'b0;
      r_trap_en        <= 1'b0;
      r_redirect_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trap) begin
            r_trap_cause <= exc_valid ? exc_cause : 6'h2B;
            r_trap_pc    <= exc_valid ? exc_pc : irq_pc;
            r_trap_en    <= 1'b1;
            r_state      <= S_TRAP;
          end else if (req_valid) begin
            r_kind    <= req_op[1:0];
            r_operand <= req_op[2] ? {27'd0, req_rs1_idx} : req_rs1_data;
            r_nz      <= req_rs1_idx != 5'd0;
            r_cnt     <= '0;
            if (req_op[1:0] == 2'b00) begin
              r_resp_valid   <= 1'b1;
              r_resp_illegal <= 1'b1;
              r_resp_rdata   <= '0;
              r_state        <= S_RESP;
            end else begin
              r_csr_addr <= req_addr;
              r_state    <= S_RD;
            end
          end
        end
        S_RD: begin
          if (csr_valid) begin
            if (w_write && w_ro) begin
              r_resp_valid   <= 1'b1;
              r_resp_illegal <= 1'b1;
              r_resp_rdata   <= '0;
              r_state        <= S_RESP;
            end else if (w_write) begin
              r_old       <= csr_rdata;
              r_csr_wdata <= w_new;
              r_csr_wen   <= 1'b1;
              r_state     <= S_WR;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= csr_rdata;
              r_state      <= S_RESP;
            end
          end else if (r_cnt == 4'd15) begin
            r_resp_valid   <= 1'b1;
            r_resp_illegal <= 1'b1;
            r_resp_rdata   <= '0;
            r_state        <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WR: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_old;
          r_state      <= S_RESP;
        end
        S_RESP: r_state <= S_IDLE;
        S_TRAP: begin
          r_redirect_valid <= 1'b1;
          r_state          <= S_REDIR;
        end
        S_REDIR: begin
          r_redirect_pc <= trap_handler;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/csr_access_ctrl.md
# csr_access_ctrl

Core-side initiator for the machine-mode CSR interface. Executes Zicsr instructions (CSRRW/RS/RC and immediate forms) as a read-modify-write sequence on the CSR port: drive address, read, compute, optionally write. Also sequences trap entry toward the CSR block (exceptions and gated external interrupts) and issues the PC redirect to the returned trap handler. Sits between the execute stage and the CSR module.

## Interface
- No parameters; timeout fixed at 16 cycles.
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous reset, active-high
- req_valid  in  1  CSR instruction request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal
- req_addr  in  12  CSR address
- req_rs1_data  in  32  rs1 value (register forms)
- req_rs1_idx  in  5  rs1 index, or zimm for immediate forms
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  old CSR value (rd writeback)
- resp_illegal  out  1  qualifies resp_valid; illegal instruction
- csr_addr  out  12  CSR address
- csr_wdata  out  32  write data
- csr_wen  out  1  one-cycle write strobe
- csr_rdata  in  32  read data
- csr_valid  in  1  csr_rdata valid this cycle
- exc_valid  in  1  synchronous exception request
- exc_cause  in  6  exception cause
- exc_pc  in  32  faulting PC
- irq_pending  in  1  external interrupt pending
- irq_pc  in  32  PC to save on interrupt
- mie  in  1  global interrupt enable (mstatus.MIE)
- trap_cause  out  6  cause to CSR block
- trap_pc  out  32  PC to CSR block (mepc)
- trap_en  out  1  one-cycle trap-update strobe
- trap_handler  in  32  handler address from CSR block
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target

## Operation
- States: IDLE, RD, WR, RESP, TRAP, REDIR.
- req_ready = (state==IDLE) && !exc_valid && !(irq_pending && mie). Trap requests are sampled only in IDLE; priority exception > interrupt > CSR request.
- Accept: latch op, addr, operand. Operand = req_rs1_data for 001–011, zero-extended req_rs1_idx for 101–111.
- Illegal op (000/100): IDLE -> RESP with resp_illegal=1, no CSR access.
- RD: csr_addr = latched addr; wait for csr_valid, capture csr_rdata. A 4-bit counter increments each RD cycle without csr_valid; on the 16th such cycle go to RESP with resp_illegal=1, no write.
- Write decision: RW/RWI always write. RS/RC/RSI/RCI write only if req_rs1_idx != 0. A write to addr[11:10]==2'b11 (read-only) gives illegal, no write, rdata discarded.
- New value: RW = op; RS = old | op; RC = old & ~op.
- WR: csr_wen=1, csr_wdata=new value, one cycle -> RESP.
- RESP: resp_valid=1 one cycle, resp_rdata=old value (0 if illegal) -> IDLE.
- TRAP: trap_cause/trap_pc latched (exception: exc_cause/exc_pc; interrupt: 6'h2B/irq_pc); trap_en=1 one cycle -> REDIR.
- REDIR: redirect_valid=1, redirect_pc=trap_handler sampled this cycle -> IDLE.
- csr_addr, csr_wdata, trap_cause, trap_pc, resp_rdata and redirect_pc hold their last value when not strobed.

## Timing
- Reset: state IDLE; every output 0, including req_ready during the reset cycle and the counter. Reset mid-sequence aborts: no csr_wen, trap_en, resp_valid or redirect_valid in the cycle after RST.
- CSR request accepted at T, csr_valid high in RD: RD at T+1, WR (csr_wen) at T+2, resp_valid at T+3. Without a write, resp_valid is at T+2. Each cycle csr_valid is late adds one cycle.
- Illegal op: resp_valid at T+1.
- Trap sampled at T: trap_en at T+1, redirect_valid at T+2, req_ready high again at T+3 at the earliest.
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP or REDIR.
- exc_valid and req_valid in the same IDLE cycle: the trap is taken and the request is not accepted; the request is held by its source.

## Test plan
- CSRRW 0x300, rs1_data=0x00001888, csr_rdata=0x00000008 with csr_valid immediate -> csr_wen at T+2 with wdata 0x00001888; resp_rdata 0x00000008 at T+3.
- CSRRS 0x341 with rs1_idx=0 -> no csr_wen; resp_valid at T+2 with resp_rdata = csr_rdata.
- CSRRCI 0x300, zimm=8, old value 0x00001888 -> wdata 0x00001880. CSRRS with mask 0x3, old value 0x4 -> wdata 0x7.
- CSRRW to 0xC00 -> resp_illegal=1, no csr_wen. req_op=100 -> resp_illegal=1 at T+1, csr_valid ignored.
- csr_valid held low -> resp_illegal at T+17 with no write. Separately, RST asserted in WR -> no csr_wen, all outputs 0.
- exc_valid (cause 2, pc 0x80) and req_valid in the same cycle -> trap_en with cause 2 and pc 0x80; redirect_pc = trap_handler; request accepted afterward. irq_pending with mie=0 -> ignored; with mie=1 -> cause 0x2B.
